// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Index width for N requesters; never below 1 so N==1 still has a legal vector.
  function automatic int arb_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the shared register arbiter; lock exists only when ARB_LOCK_EN is defined.
interface reg_write_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
`ifdef ARB_LOCK_EN
  logic [N-1:0]   lock;
`endif
  logic [N-1:0]   gnt;
  logic           busy;
  logic [W-1:0]   q;

`ifdef ARB_LOCK_EN
  modport master (output req, wdata, lock, input gnt, busy, q);
  modport slave  (input req, wdata, lock, output gnt, busy, q);
`else
  modport master (output req, wdata, input gnt, busy, q);
  modport slave  (input req, wdata, output gnt, busy, q);
`endif
endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module reg_write_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);
  logic [2*N-1:0] dbl;
  int             sel;

  // Lower copy is masked below ptr, so the lowest set bit of the doubled vector is the winner.
  always_comb begin
    dbl = {req, req};
    for (int i = 0; i < N; i++) begin
      if (i < int'(ptr)) dbl[i] = 1'b0;
    end
    sel = 0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) sel = i;
    end
    any    = |req;
    idx    = PW'(sel % N);
    onehot = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter owning one shared W-bit register; ARB_LOCK_EN adds per-requester grant hold.
//   state    | meaning
//   ST_IDLE  | no grant, q holds, waiting for any req
//   ST_GRANT | gnt one-hot on winner, q loads winner's wdata at the edge
module reg_write_arbiter
  import arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               reset,
  reg_write_arbiter_if.slave bus
);
  localparam int PW = arb_clog2(N);

  arb_state_e    state, state_n;
  logic [N-1:0]  gnt, gnt_n;
  logic [PW-1:0] ptr, ptr_n, win, win_n;
  logic [PW-1:0] ptr_after, pick_ptr, pick_idx;
  logic [N-1:0]  pick_req, pick_oh;
  logic          pick_any, hold, q_we;
  logic [W-1:0]  q;

  assign ptr_after = (win == PW'(N-1)) ? '0 : win + 1'b1;

`ifdef ARB_LOCK_EN
  assign hold = bus.lock[win];
`else
  assign hold = 1'b0;
`endif

  // During a grant the current winner is masked and the search starts past it.
  always_comb begin
    pick_req = bus.req;
    pick_ptr = ptr;
    if (state == ST_GRANT) begin
      pick_req = bus.req & ~gnt;
      pick_ptr = ptr_after;
    end
  end

  reg_write_arbiter_rr_pick #(.N(N), .PW(PW)) u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    win_n   = win;
    ptr_n   = ptr;
    q_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        gnt_n = '0;
        if (pick_any) begin
          state_n = ST_GRANT;
          gnt_n   = pick_oh;
          win_n   = pick_idx;
        end
      end
      ST_GRANT: begin
        q_we = 1'b1;
        if (!hold) begin
          ptr_n = ptr_after;
          if (pick_any) begin
            gnt_n = pick_oh;
            win_n = pick_idx;
          end else begin
            state_n = ST_IDLE;
            gnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      gnt   <= '0;
      win   <= '0;
      ptr   <= '0;
      q     <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      win   <= win_n;
      ptr   <= ptr_n;
      if (q_we) q <= bus.wdata[int'(win)*W +: W];
    end
  end

  assign bus.gnt  = gnt;
  assign bus.busy = |gnt;
  assign bus.q    = q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter (N=4/W=8 main instance, N=1/W=4 corner instance); honours ARB_LOCK_EN.
module tb_reg_write_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.N(N), .W(W)) bus ();
  reg_write_arbiter_if #(.N(1), .W(4)) bus1 ();

  reg_write_arbiter #(.N(N), .W(W)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
  reg_write_arbiter #(.N(1), .W(4)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic [N-1:0] gnt;
    int           idx;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail = 0;
  logic [W-1:0] wd[N];
  logic [N-1:0] seen = '0;
  bit           q_pend = 1'b0;
  int           q_idx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_wd(input int i, input logic [W-1:0] v);
    wd[i] = v;
    bus.wdata[i*W +: W] = v;
  endtask

  task automatic expect_gnt(input int idx);
    exp_t e;
    e.gnt = N'(1) << idx;
    e.idx = idx;
    sb.push_back(e);
  endtask

  // One cycle: sample after the edge, score grants and writes, then model requesters dropping req.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      check("rst_gnt", 32'(bus.gnt), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_q", 32'(bus.q), 0);
      q_pend = 1'b0;
      seen   = '0;
      return;
    end
    if (q_pend) begin
      check("q", 32'(bus.q), 32'(wd[q_idx]));
      q_pend = 1'b0;
    end
    if (bus.gnt != '0) begin
      check("busy", 32'(bus.busy), 1);
      if (sb.size() == 0) begin
        check("gnt_unexpected", 32'(bus.gnt), 0);
      end else begin
        e = sb.pop_front();
        check("gnt", 32'(bus.gnt), 32'(e.gnt));
        q_pend = 1'b1;
        q_idx  = e.idx;
      end
    end else begin
      check("busy_idle", 32'(bus.busy), 0);
    end
    for (int i = 0; i < N; i++) begin
      if (seen[i] && !bus.gnt[i]) begin
        bus.req[i] = 1'b0;
        seen[i]    = 1'b0;
      end
      if (bus.gnt[i]) seen[i] = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && (sb.size() != 0 || bus.gnt != '0 || q_pend); k++) tick();
    check("drain", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    bus.req   = '0;
    bus.wdata = '0;
    bus1.req  = '0;
    bus1.wdata = '0;
`ifdef ARB_LOCK_EN
    bus.lock  = '0;
    bus1.lock = '0;
`endif
    for (int i = 0; i < N; i++) set_wd(i, W'(8'h20 + 8'(i) * 8'h11));

    // reset with all requests pending, then back-to-back rotation from ptr 0
    bus.req = 4'b1111;
    tick();
    tick();
    expect_gnt(0);
    expect_gnt(1);
    expect_gnt(2);
    expect_gnt(3);
    reset = 1'b1;
    repeat (4) tick();
    check("back_to_back", sb.size(), 0);
    wait_idle(20);

    // single requester 2
    set_wd(2, 8'hA5);
    bus.req = 4'b0100;
    expect_gnt(2);
    tick();
    tick();
    check("q_a5", 32'(bus.q), 32'h0A5);
    wait_idle(20);

    // ptr now 3: 3 must beat 0
    bus.req = 4'b1001;
    expect_gnt(3);
    expect_gnt(0);
    wait_idle(20);

    // ptr now 1: 2 must beat 0
    bus.req = 4'b0101;
    expect_gnt(2);
    expect_gnt(0);
    wait_idle(20);

    // ptr 1: requester 2 gives up before being served
    bus.req = 4'b0110;
    expect_gnt(1);
    tick();
    bus.req[2] = 1'b0;
    wait_idle(20);

    // write 11 then abort a grant carrying 3C with reset
    set_wd(0, 8'h11);
    bus.req = 4'b0001;
    expect_gnt(0);
    wait_idle(20);
    check("q_11", 32'(bus.q), 32'h011);
    set_wd(1, 8'h3C);
    bus.req = 4'b0010;
    expect_gnt(1);
    tick();
    reset   = 1'b0;
    bus.req = '0;
    tick();
    reset = 1'b1;
    tick();
    check("abort_q", 32'(bus.q), 0);
    check("abort_gnt", 32'(bus.gnt), 0);

    // ptr must be 0 after reset: 0 wins over 1
    bus.req = 4'b0011;
    expect_gnt(0);
    expect_gnt(1);
    wait_idle(20);

`ifdef ARB_LOCK_EN
    bus.req = 4'b0001;
    expect_gnt(0);
    wait_idle(20);
    bus.lock[1] = 1'b1;
    bus.req = 4'b0011;
    expect_gnt(1);
    expect_gnt(1);
    expect_gnt(1);
    expect_gnt(0);
    for (int k = 0; k < 3; k++) begin
      tick();
      set_wd(1, W'(8'h50 + 8'(k)));
      if (k == 2) bus.lock[1] = 1'b0;
    end
    wait_idle(20);
`endif

    // single-requester instance: three single-cycle grants
    for (int p = 0; p < 3; p++) begin
      bus1.wdata = 4'(p * 5 + 3);
      bus1.req   = 1'b1;
      tick();
      check("n1_gnt", 32'(bus1.gnt), 1);
      check("n1_busy", 32'(bus1.busy), 1);
      bus1.req = 1'b0;
      tick();
      check("n1_q", 32'(bus1.q), 32'(p * 5 + 3));
      check("n1_gnt_end", 32'(bus1.gnt), 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
